// File: rtl/zero_scan_arbiter.sv
// zero_scan_arbiter: round-robin share of one serial zero-run detector
// among four channels; one word scanned LSB-first per job.
module zero_scan_arbiter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] data_in,
  output logic [3:0]         grant,
  output logic               busy,
  output logic               done,
  output logic [1:0]         done_id,
  output logic [CW-1:0]      zero_count,
  output logic               detect_any,
  output logic [1:0]         det_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] DET_S0 = 2'b00;
  localparam logic [1:0] DET_S1 = 2'b01;
  localparam logic [1:0] DET_S2 = 2'b10;

  logic [1:0]       r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_id;
  logic [3:0]       r_grant;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_bitcnt;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_det;
  logic             r_done;
  logic [1:0]       r_done_id;
  logic [CW-1:0]    r_zcnt;
  logic             r_detany;

  logic [7:0]       w_req2;
  logic [3:0]       w_rot;
  logic [1:0]       w_off;
  logic [1:0]       w_sel;
  logic             w_any;
  logic [WIDTH-1:0] w_ch [4];
  logic [WIDTH-1:0] w_word;
  logic             w_x;
  logic [1:0]       w_det_nxt;
  logic             w_inc;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_last;

  // Rotate requests so ptr sits at bit 0, then take the first one set
  always_comb begin
    w_req2 = {req, req};
    w_rot  = w_req2[r_ptr +: 4];
    w_any  = |req;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    else               w_off = 2'd3;
    w_sel = r_ptr + w_off;
  end

  // Split the packed channel bus and pick the winner's word
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_ch[k] = data_in[k*WIDTH +: WIDTH];
    end
    w_word = w_ch[w_sel];
  end

  // Detector next state and count step for the bit under the head
  always_comb begin
    w_x = r_sreg[0];
    if (w_x)                 w_det_nxt = DET_S0;
    else if (r_det == DET_S0) w_det_nxt = DET_S1;
    else                     w_det_nxt = DET_S2;
    w_inc     = !w_x && (r_det != DET_S0);
    w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, w_inc};
    w_last    = (r_bitcnt == CW'(WIDTH-1));
  end

  // Controller: arbitration, job sequencing and pointer update
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_id    <= 2'd0;
      r_grant <= 4'd0;
    end else begin
      r_grant <= 4'd0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id    <= w_sel;
            r_grant <= 4'b0001 << w_sel;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_last) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_ptr   <= r_id + 2'd1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: capture, serial shift, detector and running count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sreg   <= '0;
      r_bitcnt <= '0;
      r_cnt    <= '0;
      r_det    <= DET_S0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_sreg   <= w_word;
            r_bitcnt <= '0;
            r_cnt    <= '0;
            r_det    <= DET_S0;
          end
        end
        ST_SHIFT: begin
          r_sreg   <= r_sreg >> 1;
          r_bitcnt <= r_bitcnt + CW'(1);
          r_cnt    <= w_cnt_nxt;
          r_det    <= w_det_nxt;
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded with the last bit, held until next job
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_done    <= 1'b0;
      r_done_id <= 2'd0;
      r_zcnt    <= '0;
      r_detany  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_SHIFT && w_last) begin
        r_done    <= 1'b1;
        r_done_id <= r_id;
        r_zcnt    <= w_cnt_nxt;
        r_detany  <= |w_cnt_nxt;
      end
    end
  end

  assign grant      = r_grant;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign done_id    = r_done_id;
  assign zero_count = r_zcnt;
  assign detect_any = r_detany;
  assign det_state  = r_det;

endmodule

// File: tb/tb_zero_scan_arbiter.sv
// tb_zero_scan_arbiter: directed plus random jobs against a
// word-level model of arbitration and zero-run counting.
module tb_zero_scan_arbiter;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic           clock = 1'b0;
  logic           reset;
  logic [3:0]     req;
  logic [4*W-1:0] data_in;
  logic [3:0]     grant;
  logic           busy;
  logic           done;
  logic [1:0]     done_id;
  logic [CW-1:0]  zero_count;
  logic           detect_any;
  logic [1:0]     det_state;

  logic [W-1:0] word [4];
  logic [3:0]   pend;
  int           mptr;
  int           n_chk = 0;
  int           n_err = 0;
  int           w;

  zero_scan_arbiter #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .data_in    (data_in),
    .grant      (grant),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .zero_count (zero_count),
    .detect_any (detect_any),
    .det_state  (det_state)
  );

  always #5 clock = ~clock;

  always_comb begin
    data_in = '0;
    for (int k = 0; k < 4; k++) data_in[k*W +: W] = word[k];
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // First requesting channel walking the ring from ptr
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Positions i>=1 where bit i and bit i-1 are both zero
  function automatic int zruns(input logic [W-1:0] v);
    int c = 0;
    for (int i = 1; i < W; i++) if (!v[i] && !v[i-1]) c++;
    return c;
  endfunction

  // Length of zero run ending at bit i, saturated at 2
  function automatic int det_after(input logic [W-1:0] v, input int i);
    int run = 0;
    for (int j = 0; j <= i; j++) run = v[j] ? 0 : run + 1;
    return (run >= 2) ? 2 : run;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_grant"}, int'(grant), 0);
    check_eq({pfx, "_busy"}, int'(busy), 0);
    check_eq({pfx, "_done"}, int'(done), 0);
    check_eq({pfx, "_done_id"}, int'(done_id), 0);
    check_eq({pfx, "_zcount"}, int'(zero_count), 0);
    check_eq({pfx, "_detany"}, int'(detect_any), 0);
    check_eq({pfx, "_det"}, int'(det_state), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    req   = 4'd0;
    pend  = 4'd0;
    mptr  = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // One complete job: wait for grant, follow every bit, check result
  task automatic job(input bit toggle, input bit drop, output int waits);
    int           ch;
    int           zc;
    logic [W-1:0] cap;
    waits = 0;
    while (1) begin
      @(negedge clock);
      waits++;
      if (grant != 4'd0 || waits >= 20) break;
    end
    ch = pick(pend, mptr);
    if (ch < 0) begin
      check_eq("job_no_request", int'(grant), 0);
      return;
    end
    check_eq("grant", int'(grant), 1 << ch);
    if (grant == 4'd0) return;
    cap = word[ch];
    zc  = zruns(cap);
    if (drop) pend[ch] = 1'b0;
    req  = pend;
    mptr = (ch + 1) % 4;
    for (int k = 1; k <= W; k++) begin
      if (toggle && k < W) begin
        req = 4'($urandom);
        for (int c = 0; c < 4; c++) word[c] = W'($urandom);
      end else begin
        req = pend;
      end
      @(negedge clock);
      if (k == 1) check_eq("grant_pulse", int'(grant), 0);
      check_eq("busy_shift", int'(busy), 1);
      check_eq("det_state", int'(det_state), det_after(cap, k - 1));
      check_eq("done_timing", int'(done), (k == W) ? 1 : 0);
      if (k == W) begin
        check_eq("done_id", int'(done_id), ch);
        check_eq("zero_count", int'(zero_count), zc);
        check_eq("detect_any", int'(detect_any), (zc != 0) ? 1 : 0);
      end
    end
    @(negedge clock);
    check_eq("busy_fall", int'(busy), 0);
    check_eq("done_pulse", int'(done), 0);
    check_eq("zcount_held", int'(zero_count), zc);
  endtask

  initial begin
    reset = 1'b0;
    req   = 4'hF;
    pend  = 4'hF;
    mptr  = 0;
    for (int k = 0; k < 4; k++) word[k] = W'($urandom);
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b1;

    job(1'b0, 1'b0, w);
    check_eq("rst_to_grant", w, 1);
    for (int n = 0; n < 7; n++) begin
      job(1'b0, 1'b0, w);
      check_eq("contention_spacing", w, 1);
    end

    do_reset();
    word[0] = 8'h00;
    pend = 4'b0001;
    req  = pend;
    job(1'b0, 1'b1, w);
    check_eq("zeros_count7", int'(zero_count), 7);

    word[1] = 8'hAA;
    pend = 4'b0010;
    req  = pend;
    job(1'b0, 1'b1, w);

    word[1] = 8'h0F;
    pend = 4'b0010;
    req  = pend;
    job(1'b0, 1'b1, w);
    check_eq("pat0F_count3", int'(zero_count), 3);

    pend = 4'b1011;
    req  = pend;
    for (int n = 0; n < 3; n++) job(1'b1, 1'b1, w);

    do_reset();
    word[2] = W'($urandom);
    pend = 4'b0100;
    req  = pend;
    w = 0;
    while (1) begin
      @(negedge clock);
      w++;
      if (grant != 4'd0 || w >= 20) break;
    end
    check_eq("abort_grant", int'(grant), 4);
    repeat (3) @(negedge clock);
    check_eq("abort_busy", int'(busy), 1);
    reset = 1'b0;
    req   = 4'd0;
    pend  = 4'd0;
    mptr  = 0;
    #1;
    check_reset_outputs("abort");
    repeat (3) begin
      @(negedge clock);
      check_eq("abort_nodone", int'(done), 0);
    end
    reset = 1'b1;
    word[2] = 8'h00;
    pend = 4'b0100;
    req  = pend;
    job(1'b0, 1'b1, w);
    check_eq("abort_after_zc", int'(zero_count), 7);

    for (int n = 0; n < 24; n++) begin
      if ($urandom % 2) pend = pend | 4'($urandom);
      if (pend == 4'd0) pend = 4'(1 << $urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin
        if ($urandom % 2) word[k] = W'($urandom);
      end
      req = pend;
      job(1'($urandom % 2), 1'($urandom % 2), w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
